// File: rtl/key_pkg.sv
// Shared types and constants for the HID-to-Apple-1 key translation path.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_XLATE,
    ST_HELD
  } state_t;

  localparam logic [6:0] ASCII_CR  = 7'h0D;
  localparam logic [6:0] ASCII_ESC = 7'h1B;

  localparam logic [7:0] USAGE_NONE     = 8'h00;
  localparam logic [7:0] USAGE_MOD_BASE = 8'hE0;
  localparam logic [7:0] MOD_CTRL_MASK  = 8'h11;
  localparam logic [7:0] MOD_SHIFT_MASK = 8'h22;

  function automatic logic is_mod_usage(input logic [7:0] usage);
    return usage >= USAGE_MOD_BASE;
  endfunction

endpackage

// File: rtl/hid_key_translator_if.sv
// Key event input and translated-code output handshakes of the key translator.
interface hid_key_translator_if #(
  parameter int LAYOUT_BITS = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_mod;
  logic [7:0]             in_key;
  logic [LAYOUT_BITS-1:0] layout_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;

  modport master (
    output in_valid, in_mod, in_key, layout_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mod, in_key, layout_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/hid_keymap_rom.sv
// Registered keymap ROM: {layout, shift, usage} -> {valid, ascii[6:0]}, one-cycle read.
module hid_keymap_rom
  import key_pkg::*;
#(
  parameter int LAYOUT_BITS = 1
) (
  input  logic                   clk,
  input  logic [LAYOUT_BITS+8:0] addr,
  output logic [7:0]             entry
);

  logic [LAYOUT_BITS-1:0] layout;
  logic                   shift;
  logic [7:0]             usage;
  logic [7:0]             usage_eff;

  assign {layout, shift, usage} = addr;

  function automatic logic [7:0] lookup(input logic sh, input logic [7:0] u);
    logic [6:0] c;
    logic       v;
    c = 7'h00;
    v = 1'b1;
    if (u >= 8'h04 && u <= 8'h1D) begin
      c = (sh ? 7'h41 : 7'h61) + 7'(u - 8'h04);
    end else begin
      case (u)
        8'h1E:   c = sh ? 7'h21 : 7'h31;
        8'h1F:   c = sh ? 7'h40 : 7'h32;
        8'h20:   c = sh ? 7'h23 : 7'h33;
        8'h21:   c = sh ? 7'h24 : 7'h34;
        8'h22:   c = sh ? 7'h25 : 7'h35;
        8'h23:   c = sh ? 7'h5E : 7'h36;
        8'h24:   c = sh ? 7'h26 : 7'h37;
        8'h25:   c = sh ? 7'h2A : 7'h38;
        8'h26:   c = sh ? 7'h28 : 7'h39;
        8'h27:   c = sh ? 7'h29 : 7'h30;
        8'h28:   c = ASCII_CR;
        8'h29:   c = ASCII_ESC;
        8'h2A:   c = 7'h5F;
        8'h2C:   c = 7'h20;
        8'h2D:   c = sh ? 7'h5F : 7'h2D;
        8'h2E:   c = sh ? 7'h2B : 7'h3D;
        8'h2F:   c = sh ? 7'h7B : 7'h5B;
        8'h30:   c = sh ? 7'h7D : 7'h5D;
        8'h31:   c = sh ? 7'h7C : 7'h5C;
        8'h33:   c = sh ? 7'h3A : 7'h3B;
        8'h34:   c = sh ? 7'h22 : 7'h27;
        8'h35:   c = sh ? 7'h7E : 7'h60;
        8'h36:   c = sh ? 7'h3C : 7'h2C;
        8'h37:   c = sh ? 7'h3E : 7'h2E;
        8'h38:   c = sh ? 7'h3F : 7'h2F;
        default: v = 1'b0;
      endcase
    end
    return {v, c};
  endfunction

  // Layout 1 is QWERTZ: Y and Z swap places; all other layouts share the US table.
  always_comb begin
    usage_eff = usage;
    if (layout == LAYOUT_BITS'(1)) begin
      if (usage == 8'h1C)      usage_eff = 8'h1D;
      else if (usage == 8'h1D) usage_eff = 8'h1C;
    end
  end

  always_ff @(posedge clk) begin
    entry <= lookup(shift, usage_eff);
  end

endmodule

// File: rtl/hid_key_translator.sv
// HID boot-keyboard events to Apple-1 ASCII with layouts, ctrl/shift, typematic repeat and output FIFO.
module hid_key_translator
  import key_pkg::*;
#(
  parameter int LAYOUT_BITS   = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int FORCE_UPPER   = 1,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  hid_key_translator_if.slave  bus,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t                 state_q, state_d;
  logic [LAYOUT_BITS+8:0] addr_q;
  logic                   ctrl_q;
  logic [7:0]             rom_entry;
  logic [CNT_W-1:0]       cnt_q;
  logic [7:0]             held_q;

  logic       accept, start_lookup;
  logic       push;
  logic [7:0] push_data;
  logic       cnt_load_delay, cnt_load_period, cnt_dec;

  function automatic logic [6:0] fold_code(input logic [6:0] raw, input logic ctrl);
    logic [6:0] c;
    c = raw;
    if (FORCE_UPPER != 0 && c >= 7'h61 && c <= 7'h7A) c = c - 7'h20;
    if (ctrl && c >= 7'h40 && c <= 7'h5F) c = c & 7'h1F;
    return c;
  endfunction

  assign bus.in_ready = (state_q == ST_IDLE) || (state_q == ST_HELD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_lookup = accept && (bus.in_key != USAGE_NONE) && !is_mod_usage(bus.in_key);

  always_ff @(posedge clk) begin
    if (start_lookup) begin
      addr_q <= {bus.layout_sel, |(bus.in_mod & MOD_SHIFT_MASK), bus.in_key};
      ctrl_q <= |(bus.in_mod & MOD_CTRL_MASK);
    end
  end

  hid_keymap_rom #(.LAYOUT_BITS(LAYOUT_BITS)) u_rom (
    .clk   (clk),
    .addr  (addr_q),
    .entry (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    push            = 1'b0;
    push_data       = held_q;
    cnt_load_delay  = 1'b0;
    cnt_load_period = 1'b0;
    cnt_dec         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_lookup) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: state_d = ST_XLATE;
      ST_XLATE: begin
        if (rom_entry[7]) begin
          push           = 1'b1;
          push_data      = {1'b1, fold_code(rom_entry[6:0], ctrl_q)};
          cnt_load_delay = 1'b1;
          state_d        = ST_HELD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        // Any accepted event pre-empts a repeat that expires in the same cycle.
        if (accept) begin
          if (bus.in_key == USAGE_NONE) state_d = ST_IDLE;
          else if (start_lookup)        state_d = ST_LOOKUP;
        end else if (cnt_q == '0) begin
          push            = 1'b1;
          cnt_load_period = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      held_q <= '0;
    end else if (cnt_load_delay) begin
      cnt_q  <= CNT_W'(REPEAT_DELAY - 1);
      held_q <= push_data;
    end else if (cnt_load_period) begin
      cnt_q <= CNT_W'(REPEAT_PERIOD - 1);
    end else if (cnt_dec) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic          empty, full, pop, do_wr, drop;

  assign empty = (wr_q == rd_q);
  assign full  = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
  assign pop   = !empty && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_wr = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_q <= wr_q + PW'(1);
      if (pop)   rd_q <= rd_q + PW'(1);
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 8'h00 : mem[rd_q[AW-1:0]];

endmodule

// File: tb/tb_hid_key_translator.sv
// Directed bench for hid_key_translator: lookup, modifiers, typematic repeat, FIFO overflow, reset.
module tb_hid_key_translator;

  logic clk;
  logic rst;
  logic overflow;
  logic overflow_clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  hid_key_translator_if #(.LAYOUT_BITS(1)) bus ();

  hid_key_translator #(
    .LAYOUT_BITS   (1),
    .FIFO_DEPTH    (4),
    .FORCE_UPPER   (1),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one event for a single cycle once the translator is ready for it.
  task automatic press(input logic [7:0] k, input logic [7:0] m);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_before_press", 8'(bus.in_ready), 8'h01);
    bus.in_valid = 1'b1;
    bus.in_key   = k;
    bus.in_mod   = m;
    tick();
    bus.in_valid = 1'b0;
    bus.in_key   = 8'h00;
    bus.in_mod   = 8'h00;
  endtask

  // Key accepted on the last edge: nothing after one edge, the code after two.
  task automatic expect_code(input string tag, input logic [7:0] exp);
    tick();
    check({tag, "_lat1"}, 8'(bus.out_valid), 8'h00);
    tick();
    check({tag, "_valid"}, 8'(bus.out_valid), 8'h01);
    check({tag, "_data"}, bus.out_data, exp);
  endtask

  task automatic type_key(input string tag, input logic [7:0] k, input logic [7:0] m,
                          input logic [7:0] exp);
    press(k, m);
    expect_code(tag, exp);
    press(8'h00, 8'h00);
    check({tag, "_drained"}, 8'(bus.out_valid), 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end

  initial begin
    int seen;
    rst            = 1'b1;
    overflow_clr   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_key     = 8'h00;
    bus.in_mod     = 8'h00;
    bus.layout_sel = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready", 8'(bus.in_ready), 8'h01);
    check("rst_out_valid", 8'(bus.out_valid), 8'h00);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_overflow", 8'(overflow), 8'h00);

    // Plain keys, shift, ctrl
    type_key("key_a", 8'h04, 8'h00, 8'hC1);
    type_key("key_enter", 8'h28, 8'h00, 8'h8D);
    type_key("key_1_lshift", 8'h1E, 8'h02, 8'hA1);
    type_key("key_1_rshift", 8'h1E, 8'h20, 8'hA1);
    type_key("key_1", 8'h1E, 8'h00, 8'hB1);
    type_key("key_ctrl_c", 8'h06, 8'h01, 8'h83);
    type_key("key_rctrl_c", 8'h06, 8'h10, 8'h83);
    type_key("key_esc", 8'h29, 8'h00, 8'h9B);
    type_key("layout0_y", 8'h1C, 8'h00, 8'hD9);
    bus.layout_sel = 1'b1;
    type_key("layout1_y", 8'h1C, 8'h00, 8'hDA);
    bus.layout_sel = 1'b0;

    // Release and modifier usages from IDLE are not looked up
    press(8'h00, 8'h00);
    seen = 0;
    repeat (4) begin
      if (!bus.in_ready || bus.out_valid) seen++;
      tick();
    end
    check("none_stays_idle", 8'(seen), 8'h00);
    press(8'hE1, 8'h02);
    seen = 0;
    repeat (4) begin
      if (!bus.in_ready || bus.out_valid) seen++;
      tick();
    end
    check("modusage_stays_idle", 8'(seen), 8'h00);

    // Typematic repeat: first, +20, +8, then release stops it
    press(8'h04, 8'h00);
    expect_code("hold_first", 8'hC1);
    repeat (19) tick();
    check("hold_before_rep1", 8'(bus.out_valid), 8'h00);
    tick();
    check("hold_rep1_valid", 8'(bus.out_valid), 8'h01);
    check("hold_rep1_data", bus.out_data, 8'hC1);
    repeat (7) tick();
    check("hold_before_rep2", 8'(bus.out_valid), 8'h00);
    tick();
    check("hold_rep2_valid", 8'(bus.out_valid), 8'h01);
    check("hold_rep2_data", bus.out_data, 8'hC1);
    press(8'h00, 8'h00);
    seen = 0;
    repeat (40) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("release_no_repeat", 8'(seen), 8'h00);

    // New key accepted in the very cycle the repeat counter expires
    press(8'h04, 8'h00);
    expect_code("expiry_first", 8'hC1);
    repeat (19) tick();
    press(8'h05, 8'h00);
    check("expiry_no_push", 8'(bus.out_valid), 8'h00);
    tick();
    check("expiry_lat1", 8'(bus.out_valid), 8'h00);
    tick();
    check("expiry_new_valid", 8'(bus.out_valid), 8'h01);
    check("expiry_new_data", bus.out_data, 8'hC2);
    press(8'h00, 8'h00);
    check("expiry_drained", 8'(bus.out_valid), 8'h00);

    // Overflow: six keys into a 4-deep FIFO with the consumer stalled
    bus.out_ready = 1'b0;
    press(8'h04, 8'h00);
    press(8'h05, 8'h00);
    press(8'h06, 8'h00);
    press(8'h07, 8'h00);
    press(8'h08, 8'h00);
    press(8'h09, 8'h00);
    press(8'h00, 8'h00);
    tick();
    check("ovf_set", 8'(overflow), 8'h01);
    check("ovf_head_stable", bus.out_data, 8'hC1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_cleared", 8'(overflow), 8'h00);
    check("ovf_head_still", bus.out_data, 8'hC1);
    bus.out_ready = 1'b1;
    check("drain0", bus.out_data, 8'hC1);
    tick();
    check("drain1", bus.out_data, 8'hC2);
    tick();
    check("drain2", bus.out_data, 8'hC3);
    tick();
    check("drain3", bus.out_data, 8'hC4);
    tick();
    check("drain_empty", 8'(bus.out_valid), 8'h00);

    // Reset while HELD with a code queued
    bus.out_ready = 1'b0;
    press(8'h04, 8'h00);
    tick();
    tick();
    check("pre_rst_queued", 8'(bus.out_valid), 8'h01);
    do_reset();
    check("rst_held_valid", 8'(bus.out_valid), 8'h00);
    check("rst_held_ready", 8'(bus.in_ready), 8'h01);
    check("rst_held_data", bus.out_data, 8'h00);
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (30) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("rst_held_quiet", 8'(seen), 8'h00);

    // Reset while LOOKUP
    press(8'h05, 8'h00);
    do_reset();
    check("rst_lookup_ready", 8'(bus.in_ready), 8'h01);
    seen = 0;
    repeat (10) begin
      if (bus.out_valid || !bus.in_ready) seen++;
      tick();
    end
    check("rst_lookup_quiet", 8'(seen), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
